array_access_arbiter: RTL and testbench
=======================================

Name: array_access_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares one on-chip byte array (DEPTH x WIDTH) between NUM_REQ requesters.
- Sits beside the array test designs. It gives the cocotb benches a shared-resource block with real arbitration, burst counting and registered read data, and it exposes the whole array contents for inspection.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DEPTH, 4, number of array elements (power of two, >=2); AW = $clog2(DEPTH)
- WIDTH, 8, element width in bits
- Derived: IW = $clog2(NUM_REQ)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request; held high for the whole burst
- req_write  in  NUM_REQ  1 = write burst, 0 = read burst
- req_addr  in  NUM_REQ*AW  start address; requester i uses slice [i*AW +: AW]
- req_len  in  NUM_REQ*2  beats minus 1 (0..3)
- req_wdata  in  NUM_REQ*WIDTH  write data for the current beat; sampled on each beat
- grant  out  NUM_REQ  one-hot grant, registered
- beat  out  1  a beat is performed this cycle
- last  out  1  this beat is the final beat of the burst
- rd_valid  out  1  rd_data/rd_id valid
- rd_data  out  WIDTH  read data
- rd_id  out  IW  index of the requester that owns rd_data
- mem_out  out  DEPTH*WIDTH  array contents; element k is at [k*WIDTH +: WIDTH]

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; rr_ptr=0.
  - grant, beat, last, rd_valid all 0; rd_data=0; rd_id=0.
  - All array elements cleared to 0.
  - Reset mid-burst aborts the burst with no further array update.
- State IDLE:
  - If any req_valid is high, pick the winner: the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Latch the winner's index, write flag, start address and length.
  - Drive grant one-hot from the next cycle; go to BURST.
  - With no requests, stay in IDLE with grant=0.
- State BURST (beat_cnt starts at 0):
  - If req_valid[winner]=1, perform one beat:
    - address = (start + beat_cnt) mod DEPTH, so addresses wrap around.
    - Write: array[address] <= req_wdata slice of the winner, visible on mem_out the next cycle.
    - Read: rd_data <= array[address]; rd_valid=1 and rd_id=winner in the next cycle (1-cycle read latency).
    - beat=1 combinationally in the beat cycle.
  - If beat_cnt == latched len: last=1. Next cycle grant=0, state=IDLE, rr_ptr = (winner+1) mod NUM_REQ.
  - Otherwise beat_cnt increments.
  - If req_valid[winner] drops while in BURST (abort):
    - No beat, no array change, beat=0.
    - Go to IDLE next cycle; rr_ptr advances as on normal completion.
- Timing:
  - There is always one IDLE turnaround cycle between bursts.
  - Minimum latency from request to first beat is 1 cycle (request seen in IDLE, beat in the first BURST cycle).
  - Burst of len L occupies L+1 BURST cycles.
- Ordering:
  - A read beat at an address written earlier in the same or a prior burst returns the updated value.
  - A read and a write never occur in the same cycle (single winner).
- Other rules:
  - Requests from non-granted requesters are ignored and never lost; they are simply re-evaluated at the next IDLE cycle.
  - req_write, req_addr and req_len changes after grant have no effect; only req_valid and req_wdata are live during BURST.
  - rd_valid is a single-cycle pulse per read beat. Back-to-back read beats give consecutive rd_valid cycles.

Test Plan:
- Reset, then idle 5 cycles: grant=0, beat=0, rd_valid=0; mem_out all zero.
- Requester 1 write, addr=2, len=3, wdata 0xA1,0xB2,0xC3,0xD4 per beat: beats at addresses 2,3,0,1 (wrap). mem_out = {el0=0xC3, el1=0xD4, el2=0xA1, el3=0xB2}. last on the 4th beat; grant drops the next cycle.
- Requester 3 read of the same data, addr=0, len=1: rd_valid two consecutive cycles with rd_id=3, rd_data 0xC3 then 0xD4, each 1 cycle after its beat.
- Requesters 0,1,2,3 all request len=0 reads simultaneously and continuously, rr_ptr=0 after reset: grant order is 0,1,2,3,0. Each grant lasts 1 cycle and is separated by one IDLE cycle.
- Requester 2 write len=3, req_valid deasserted after 2 beats (0x11, 0x22 at addr 0): only el0=0x11 and el1=0x22 change, no last pulse. Next winner search starts at requester 3.
- rst asserted in the 2nd beat of a 4-beat write: the next cycle shows grant=0, state IDLE, mem_out all zero; a following request is served normally.

Source files
------------

// File: rtl/array_access_arbiter.sv
// array_access_arbiter
// Round-robin arbiter plus burst sequencer in front of a small register array.
// One requester owns the array at a time. Its burst of 1..4 beats walks
// consecutive addresses, wrapping modulo DEPTH. Writes update the array.
// Reads return data one cycle after the beat. The whole array is exported
// on mem_out.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no owner; pick the next winner from rr_ptr upward, latch its burst
// ST_BURST   | winner owns the array; one beat per cycle while its req_valid holds
module array_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4,
  parameter int WIDTH   = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*2-1:0]     req_len,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     beat,
  output logic                     last,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [IW-1:0]            rd_id,
  output logic [DEPTH*WIDTH-1:0]   mem_out
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    win_q;
  logic             wr_q;
  logic [AW-1:0]    start_q;
  logic [1:0]       len_q;
  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             any_req;
  logic [IW-1:0]    pick_idx;
  logic             win_valid;
  logic [AW-1:0]    beat_addr;
  logic [WIDTH-1:0] win_wdata;
  logic [IW-1:0]    rr_next;
  logic             burst_done;

  assign any_req = |req_valid;

  // Winner search: first requesting index at or above rr_ptr, wrapping.
  always_comb begin : pick_blk
    int  cand;
    logic found;
    cand     = 0;
    found    = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        pick_idx = IW'(cand);
      end
    end
  end

  // Beat qualification, address generation and burst termination.
  always_comb begin
    win_valid  = req_valid[win_q];
    win_wdata  = req_wdata[int'(win_q)*WIDTH +: WIDTH];
    beat_addr  = AW'({2'b00, start_q} + {{AW{1'b0}}, cnt_q});
    beat       = (state == ST_BURST) && win_valid;
    last       = beat && (cnt_q == len_q);
    burst_done = (state == ST_BURST) && (!win_valid || (cnt_q == len_q));
    rr_next    = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
  end

  // Arbitration FSM: latch the winner's burst in IDLE, count beats in BURST.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      win_q   <= '0;
      wr_q    <= 1'b0;
      start_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            win_q   <= pick_idx;
            wr_q    <= req_write[pick_idx];
            start_q <= req_addr[int'(pick_idx)*AW +: AW];
            len_q   <= req_len[int'(pick_idx)*2 +: 2];
            cnt_q   <= '0;
            grant   <= NUM_REQ'(1) << pick_idx;
            state   <= ST_BURST;
          end
        end
        ST_BURST: begin
          // Completion and abort both hand the pointer past the winner.
          if (burst_done) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= rr_next;
          end else if (beat) begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Array storage: cleared on reset, written on write beats only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (beat && wr_q) begin
      mem[beat_addr] <= win_wdata;
    end
  end

  // Registered read path: one-cycle pulse per read beat, data held between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_id    <= '0;
    end else begin
      rd_valid <= beat && !wr_q;
      if (beat && !wr_q) begin
        rd_data <= mem[beat_addr];
        rd_id   <= win_q;
      end
    end
  end

  // Flattened view of the array for inspection.
  for (genvar g = 0; g < DEPTH; g++) begin : g_mem_out
    assign mem_out[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: tb/tb_array_access_arbiter.sv
// Bench for array_access_arbiter: directed vector table, hand sequences for
// round-robin / abort / reset corner cases, then random traffic checked
// against a transaction-level model of the arbiter.
module tb_array_access_arbiter;

  localparam int NR = 4;
  localparam int DP = 4;
  localparam int WD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid, req_write;
  logic [7:0]    req_addr, req_len;
  logic [31:0]   req_wdata;
  logic [3:0]    grant;
  logic          beat, last, rd_valid;
  logic [7:0]    rd_data;
  logic [1:0]    rd_id;
  logic [31:0]   mem_out;

  int total = 0;
  int bad   = 0;

  array_access_arbiter #(.NUM_REQ(NR), .DEPTH(DP), .WIDTH(WD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .grant     (grant),
    .beat      (beat),
    .last      (last),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_id     (rd_id),
    .mem_out   (mem_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int         m_owner;   // -1 when nobody owns the array
  int         m_done;    // beats already performed in this burst
  int         m_rr;
  bit         m_wr;
  int         m_addr, m_len;
  logic [7:0] m_mem [DP];
  logic       m_rdv;
  logic [7:0] m_rdd;
  logic [1:0] m_rdid;

  task automatic model_reset();
    m_owner = -1; m_done = 0; m_rr = 0; m_wr = 0; m_addr = 0; m_len = 0;
    for (int k = 0; k < DP; k++) m_mem[k] = 8'h00;
    m_rdv = 0; m_rdd = 8'h00; m_rdid = 2'd0;
  endtask

  task automatic model_check();
    logic [3:0] eg;
    logic eb, el;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    eb = (m_owner >= 0) && req_valid[m_owner];
    el = eb && (m_done == m_len);
    chk("m_grant", 32'(grant), 32'(eg));
    chk("m_beat", 32'(beat), 32'(eb));
    chk("m_last", 32'(last), 32'(el));
    chk("m_rd_valid", 32'(rd_valid), 32'(m_rdv));
    if (m_rdv) begin
      chk("m_rd_data", 32'(rd_data), 32'(m_rdd));
      chk("m_rd_id", 32'(rd_id), 32'(m_rdid));
    end
    chk("m_mem_out", mem_out, {m_mem[3], m_mem[2], m_mem[1], m_mem[0]});
  endtask

  task automatic model_edge();
    int a, j;
    if (rst) begin
      model_reset();
      return;
    end
    m_rdv = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        j = (m_rr + k) % NR;
        if (req_valid[j]) begin
          m_owner = j; m_done = 0;
          m_wr = req_write[j];
          m_addr = int'(req_addr[j*2 +: 2]);
          m_len = int'(req_len[j*2 +: 2]);
          break;
        end
      end
    end else if (req_valid[m_owner]) begin
      a = (m_addr + m_done) % DP;
      if (m_wr) m_mem[a] = req_wdata[m_owner*8 +: 8];
      else begin
        m_rdv = 1; m_rdd = m_mem[a]; m_rdid = 2'(m_owner);
      end
      if (m_done == m_len) begin
        m_rr = (m_owner + 1) % NR; m_owner = -1;
      end else m_done++;
    end else begin
      m_rr = (m_owner + 1) % NR; m_owner = -1;
    end
  endtask

  // Called at a negedge with inputs already applied.
  task automatic cycle();
    #1;
    model_check();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] v, input logic [3:0] w, input logic [7:0] a,
                        input logic [7:0] l, input logic [31:0] d);
    req_valid = v; req_write = w; req_addr = a; req_len = l; req_wdata = d;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic [3:0]  v, w;
    logic [7:0]  a, l;
    logic [31:0] d;
    logic [3:0]  g;
    logic        b, la, rv;
    logic [7:0]  rd;
    logic [1:0]  rid;
    logic [31:0] mem;
  } vec_t;

  vec_t tbl[$];
  int   seen[$];

  initial begin
    // 5 idle cycles after reset
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 32'h0});
    // requester 1 write, addr 2, len 3 -> addresses 2,3,0,1
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 8'h08, 8'h0C, 32'h0,      4'h0,    1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 32'h0});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 8'h08, 8'h0C, 32'h0000A100, 4'b0010, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 32'h0});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 8'h08, 8'h0C, 32'h0000B200, 4'b0010, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 32'h00A10000});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 8'h08, 8'h0C, 32'h0000C300, 4'b0010, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 32'hB2A10000});
    tbl.push_back('{1'b0, 4'b0010, 4'b0010, 8'h08, 8'h0C, 32'h0000D400, 4'b0010, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 32'hB2A100C3});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 32'h0,      4'h0,    1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 32'hB2A1D4C3});
    // requester 3 read, addr 0, len 1
    tbl.push_back('{1'b0, 4'b1000, 4'b0000, 8'h00, 8'h40, 32'h0, 4'h0,    1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 32'hB2A1D4C3});
    tbl.push_back('{1'b0, 4'b1000, 4'b0000, 8'h00, 8'h40, 32'h0, 4'b1000, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 32'hB2A1D4C3});
    tbl.push_back('{1'b0, 4'b1000, 4'b0000, 8'h00, 8'h40, 32'h0, 4'b1000, 1'b1, 1'b1, 1'b1, 8'hC3, 2'd3, 32'hB2A1D4C3});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 32'h0, 4'h0,    1'b0, 1'b0, 1'b1, 8'hD4, 2'd3, 32'hB2A1D4C3});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 32'h0, 4'h0,    1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 32'hB2A1D4C3});

    rst = 1'b1;
    set_in(4'h0, 4'h0, 8'h00, 8'h00, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      set_in(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].l, tbl[i].d);
      #1;
      chk($sformatf("row%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("row%0d_beat", i), 32'(beat), 32'(tbl[i].b));
      chk($sformatf("row%0d_last", i), 32'(last), 32'(tbl[i].la));
      chk($sformatf("row%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk($sformatf("row%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].rd));
        chk($sformatf("row%0d_rd_id", i), 32'(rd_id), 32'(tbl[i].rid));
      end
      chk($sformatf("row%0d_mem", i), mem_out, tbl[i].mem);
      cycle();
    end

    // Round robin: all four request len-0 reads continuously.
    begin
      logic [3:0] exp_g [10];
      exp_g = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
      set_in(4'hF, 4'h0, 8'h00, 8'h00, 32'h0);
      for (int i = 0; i < 10; i++) begin
        #1;
        chk($sformatf("rr_grant%0d", i), 32'(grant), 32'(exp_g[i]));
        if (grant != 4'h0) seen.push_back(int'(grant));
        cycle();
      end
      chk("rr_count", 32'(seen.size()), 32'd5);
      set_in(4'h0, 4'h0, 8'h00, 8'h00, 32'h0);
      cycle();
    end

    // Abort: requester 2 write len 3 at addr 0, dropped after two beats.
    set_in(4'b0100, 4'b0100, 8'h00, 8'h30, 32'h0);
    cycle();
    req_wdata = 32'h00110000;
    #1; chk("ab_beat1", 32'(beat), 32'd1); chk("ab_last1", 32'(last), 32'd0);
    cycle();
    req_wdata = 32'h00220000;
    #1; chk("ab_beat2", 32'(beat), 32'd1); chk("ab_last2", 32'(last), 32'd0);
    cycle();
    req_valid = 4'b0000;
    #1; chk("ab_beat3", 32'(beat), 32'd0); chk("ab_last3", 32'(last), 32'd0);
    cycle();
    set_in(4'hF, 4'h0, 8'h00, 8'h00, 32'h0);
    #1; chk("ab_mem", mem_out, 32'hB2A12211);
    cycle();
    #1; chk("ab_next_winner", 32'(grant), 32'h8);
    cycle();
    set_in(4'h0, 4'h0, 8'h00, 8'h00, 32'h0);
    cycle();

    // Reset during the second beat of a 4-beat write.
    set_in(4'b0010, 4'b0010, 8'h00, 8'h0C, 32'h0);
    cycle();
    req_wdata = 32'h00005500;
    cycle();
    req_wdata = 32'h00006600;
    rst = 1'b1;
    #1; chk("rs_beat2", 32'(beat), 32'd1);
    cycle();
    rst = 1'b0;
    set_in(4'h0, 4'h0, 8'h00, 8'h00, 32'h0);
    #1; chk("rs_grant", 32'(grant), 32'd0); chk("rs_mem", mem_out, 32'h0);
    cycle();
    set_in(4'b0001, 4'b0001, 8'h03, 8'h00, 32'h0);
    cycle();
    req_wdata = 32'h00000077;
    #1; chk("rs_beat", 32'(beat), 32'd1); chk("rs_last", 32'(last), 32'd1);
    cycle();
    set_in(4'h0, 4'h0, 8'h00, 8'h00, 32'h0);
    #1; chk("rs_mem_after", mem_out, 32'h77000000);
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_in(4'($urandom) | 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), $urandom);
      cycle();
    end
    rst = 1'b0;
    set_in(4'h0, 4'h0, 8'h00, 8'h00, 32'h0);
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
